// File: rtl/imem_stream_loader.sv
`default_nettype none
// ============================================================================
// imem_stream_loader : instruction memory with little-endian byte-stream loader
// Revision: 1.0
// ============================================================================
module imem_stream_loader #(
   parameter int          DEPTH_BYTES = 1024,
   parameter int          AW          = 32,
   parameter logic [31:0] NOP         = 32'h00000013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic [AW-1:0] load_base,
   input  logic          load_stop,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          busy,
   output logic          load_done,
   output logic          overflow,
   output logic [AW-1:0] word_count,
   input  logic          fetch_en,
   input  logic [AW-1:0] pc,
   output logic [31:0]   instruction,
   output logic          instr_valid,
   output logic          fetch_fault
);

   localparam int            LW      = $clog2(DEPTH_BYTES);
   localparam int            WORDS   = DEPTH_BYTES / 4;
   localparam logic [AW-1:0] C_DEPTH = AW'(DEPTH_BYTES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic [31:0] mem [WORDS];

   state_t        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [23:0]   pack_q, pack_d;
   logic [AW-1:0] word_count_q, word_count_d;
   logic          overflow_q, overflow_d;
   logic          load_done_q, load_done_d;
   logic          byte_ready_q, byte_ready_d;
   logic          busy_q, busy_d;
   logic [31:0]   instruction_q, instruction_d;
   logic          instr_valid_q, instr_valid_d;
   logic          fetch_fault_q, fetch_fault_d;

   logic          mem_we;
   logic [LW-3:0] mem_widx;
   logic [31:0]   mem_wdata;
   logic [AW-1:0] wptr_inc;
   logic [31:0]   flush_word;
   logic          accept;

   assign wptr_inc = wptr_q + AW'(4);
   assign accept   = byte_valid && byte_ready_q;

   // Lanes beyond the bytes received are zeroed when a partial word is flushed.
   assign flush_word = {8'h00,
                        (byte_cnt_q == 2'd3) ? pack_q[23:16] : 8'h00,
                        (byte_cnt_q >= 2'd2) ? pack_q[15:8]  : 8'h00,
                        (byte_cnt_q >= 2'd1) ? pack_q[7:0]   : 8'h00};

   always_comb begin
      state_d       = state_q;
      wptr_d        = wptr_q;
      byte_cnt_d    = byte_cnt_q;
      pack_d        = pack_q;
      word_count_d  = word_count_q;
      overflow_d    = overflow_q;
      mem_we        = 1'b0;
      mem_widx      = wptr_q[LW-1:2];
      mem_wdata     = {byte_data, pack_q};

      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               wptr_d       = {load_base[AW-1:2], 2'b00};
               byte_cnt_d   = 2'd0;
               word_count_d = '0;
               overflow_d   = 1'b0;
               if (load_base >= C_DEPTH) begin
                  overflow_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (byte_cnt_q == 2'd3) begin
                  mem_we       = 1'b1;
                  wptr_d       = wptr_inc;
                  word_count_d = word_count_q + AW'(1);
                  byte_cnt_d   = 2'd0;
                  if (wptr_inc == C_DEPTH) begin
                     overflow_d = 1'b1;
                     state_d    = S_DONE;
                  end
               end else begin
                  case (byte_cnt_q)
                     2'd0:    pack_d[7:0]   = byte_data;
                     2'd1:    pack_d[15:8]  = byte_data;
                     default: pack_d[23:16] = byte_data;
                  endcase
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
            if (load_stop && (state_d == S_LOAD)) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (byte_cnt_q != 2'd0) begin
               mem_we       = 1'b1;
               mem_wdata    = flush_word;
               word_count_d = word_count_q + AW'(1);
            end
            byte_cnt_d = 2'd0;
            state_d    = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      byte_ready_d = (state_d == S_LOAD);
      busy_d       = (state_d == S_LOAD) || (state_d == S_FLUSH);
      load_done_d  = (state_d == S_DONE);

      instruction_d = instruction_q;
      instr_valid_d = instr_valid_q;
      fetch_fault_d = fetch_fault_q;
      if (fetch_en) begin
         if ((pc[1:0] == 2'b00) && (pc < C_DEPTH) && !busy_q) begin
            instruction_d = mem[pc[LW-1:2]];
            instr_valid_d = 1'b1;
            fetch_fault_d = 1'b0;
         end else begin
            instruction_d = NOP;
            instr_valid_d = 1'b0;
            fetch_fault_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wptr_q        <= '0;
         byte_cnt_q    <= 2'd0;
         pack_q        <= '0;
         word_count_q  <= '0;
         overflow_q    <= 1'b0;
         load_done_q   <= 1'b0;
         byte_ready_q  <= 1'b0;
         busy_q        <= 1'b0;
         instruction_q <= NOP;
         instr_valid_q <= 1'b0;
         fetch_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wptr_q        <= wptr_d;
         byte_cnt_q    <= byte_cnt_d;
         pack_q        <= pack_d;
         word_count_q  <= word_count_d;
         overflow_q    <= overflow_d;
         load_done_q   <= load_done_d;
         byte_ready_q  <= byte_ready_d;
         busy_q        <= busy_d;
         instruction_q <= instruction_d;
         instr_valid_q <= instr_valid_d;
         fetch_fault_q <= fetch_fault_d;
      end
   end

   // Storage is not reset; a write landing on a reset edge belongs to an aborted load.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[mem_widx] <= mem_wdata;
      end
   end

   assign byte_ready  = byte_ready_q;
   assign busy        = busy_q;
   assign load_done   = load_done_q;
   assign overflow    = overflow_q;
   assign word_count  = word_count_q;
   assign instruction = instruction_q;
   assign instr_valid = instr_valid_q;
   assign fetch_fault = fetch_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_stream_loader : directed stimulus with queue-based scoreboard
// Revision: 1.0
// ============================================================================
module tb_imem_stream_loader;

   localparam logic [31:0] NOPW = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [31:0] load_base;
   logic        load_stop;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        busy;
   logic        load_done;
   logic        overflow;
   logic [31:0] word_count;
   logic        fetch_en;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        fetch_fault;

   imem_stream_loader #(.DEPTH_BYTES(1024), .AW(32), .NOP(NOPW)) dut (
      .clk(clk), .rst(rst),
      .load_start(load_start), .load_base(load_base), .load_stop(load_stop),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .busy(busy), .load_done(load_done), .overflow(overflow), .word_count(word_count),
      .fetch_en(fetch_en), .pc(pc),
      .instruction(instruction), .instr_valid(instr_valid), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] ins;
      logic        v;
      logic        f;
   } fexp_t;

   typedef struct packed {
      logic [31:0] wc;
      logic        ov;
   } lexp_t;

   fexp_t fq[$];
   lexp_t lq[$];
   int    errors = 0;
   int    checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops an expected fetch result for every fetch edge and an
   // expected load result for every load_done pulse.
   initial begin
      logic  f;
      fexp_t fe;
      lexp_t le;
      forever begin
         @(posedge clk);
         f = fetch_en && !rst;
         #1;
         if (f) begin
            if (fq.size() == 0) begin
               checks++; errors++;
               $display("FAIL fetch_unexpected: got fetch, expected none queued");
            end else begin
               fe = fq.pop_front();
               chk("fetch_instr", instruction, fe.ins);
               chk("fetch_valid", {31'b0, instr_valid}, {31'b0, fe.v});
               chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, fe.f});
            end
         end
         if (load_done && !rst) begin
            if (lq.size() == 0) begin
               checks++; errors++;
               $display("FAIL load_done_unexpected: got pulse, expected none");
            end else begin
               le = lq.pop_front();
               chk("word_count", word_count, le.wc);
               chk("overflow", {31'b0, overflow}, {31'b0, le.ov});
            end
         end
      end
   end

   task automatic exp_load(input logic [31:0] wc, input logic ov);
      lexp_t e;
      e.wc = wc; e.ov = ov;
      lq.push_back(e);
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] ins, input logic v, input logic f);
      fexp_t e;
      e.ins = ins; e.v = v; e.f = f;
      fq.push_back(e);
      fetch_en = 1'b1;
      pc       = a;
      @(negedge clk);
      fetch_en = 1'b0;
   endtask

   task automatic start_load(input logic [31:0] base);
      load_start = 1'b1;
      load_base  = base;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      chk("byte_ready", {31'b0, byte_ready}, 32'd1);
      byte_valid = 1'b1;
      byte_data  = b;
      load_stop  = stop;
      @(negedge clk);
      byte_valid = 1'b0;
      load_stop  = 1'b0;
   endtask

   task automatic stop_load();
      load_stop = 1'b1;
      @(negedge clk);
      load_stop = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (load_done) break;
      end
      if (n == 20) begin
         checks++; errors++;
         $display("FAIL load_done_timeout: got no pulse, expected pulse within 20 cycles");
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_load_done"}, {31'b0, load_done}, 32'd0);
      chk({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
      chk({tag, "_word_count"}, word_count, 32'd0);
      chk({tag, "_instruction"}, instruction, NOPW);
      chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
      chk({tag, "_fetch_fault"}, {31'b0, fetch_fault}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] prog [8];
      logic [7:0] bp   [6];
      int         pulses;
      int         rdy;
      prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
      bp   = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};

      rst = 1'b1; load_start = 1'b0; load_base = '0; load_stop = 1'b0;
      byte_valid = 1'b0; byte_data = '0; fetch_en = 1'b0; pc = '0;
      repeat (3) @(negedge clk);
      chk_reset_state("rst");
      rst = 1'b0;
      @(negedge clk);

      // Two full words at base 0
      start_load(32'd0);
      exp_load(32'd2, 1'b0);
      for (int i = 0; i < 8; i++) send(prog[i], 1'b0);
      stop_load();
      chk("flush_busy", {31'b0, busy}, 32'd1);
      chk("flush_no_done", {31'b0, load_done}, 32'd0);
      @(negedge clk);
      chk("done_pulse", {31'b0, load_done}, 32'd1);
      chk("done_not_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("done_single", {31'b0, load_done}, 32'd0);
      fetch(32'd0, 32'h00000013, 1'b1, 1'b0);
      fetch(32'd4, 32'h00500093, 1'b1, 1'b0);
      pc = 32'd2;
      @(negedge clk);
      chk("hold_instr", instruction, 32'h00500093);
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);

      // Partial word flush
      start_load(32'd16);
      exp_load(32'd1, 1'b0);
      send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
      stop_load();
      wait_done();
      fetch(32'd16, 32'h00CCBBAA, 1'b1, 1'b0);

      // Overflow at the top of memory
      start_load(32'd1016);
      exp_load(32'd2, 1'b1);
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      chk("ovf_ready_low", {31'b0, byte_ready}, 32'd0);
      chk("ovf_flag", {31'b0, overflow}, 32'd1);
      pulses = int'(load_done);
      rdy    = 0;
      byte_valid = 1'b1; byte_data = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         pulses += int'(load_done);
         rdy    += int'(byte_ready);
      end
      byte_valid = 1'b0;
      chk("ovf_done_pulses", pulses, 32'd1);
      chk("ovf_ready_cycles", rdy, 32'd0);
      chk("ovf_sticky", {31'b0, overflow}, 32'd1);
      fetch(32'd1016, 32'h04030201, 1'b1, 1'b0);
      fetch(32'd1020, 32'h08070605, 1'b1, 1'b0);
      fetch(32'd0, 32'h00000013, 1'b1, 1'b0);

      // Fetch faults
      fetch(32'd2, NOPW, 1'b0, 1'b1);
      fetch(32'd1024, NOPW, 1'b0, 1'b1);
      fetch(32'd4, 32'h00500093, 1'b1, 1'b0);

      // Busy fetch, then reset mid-load after six bytes
      start_load(32'd32);
      chk("ovf_cleared", {31'b0, overflow}, 32'd0);
      fetch(32'd0, NOPW, 1'b0, 1'b1);
      for (int i = 1; i <= 6; i++) send(8'(i * 16 + i), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_state("midrst");
      rst = 1'b0;
      @(negedge clk);
      fetch(32'd32, 32'h44332211, 1'b1, 1'b0);

      // Back-pressure with load_stop on the final byte
      start_load(32'd48);
      chk("restart_busy", {31'b0, busy}, 32'd1);
      exp_load(32'd2, 1'b0);
      for (int i = 0; i < 6; i++) begin
         send(bp[i], (i == 5));
         if (i != 5) @(negedge clk);
      end
      wait_done();
      fetch(32'd48, 32'hEFBEADDE, 1'b1, 1'b0);
      fetch(32'd52, 32'h00000201, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      chk("fetch_queue_empty", fq.size(), 32'd0);
      chk("load_queue_empty", lq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_stream_loader.md
# imem_stream_loader

Parametrised instruction memory with a built-in byte-stream loader for the RISC-V core. A host or UART bridge streams program bytes in little-endian order over a valid/ready handshake. An FSM packs them into 32-bit words and writes them at an auto-incrementing byte address. The fetch port gives the core a registered, one-cycle-latency read with alignment and range checking, and is blocked while a load is in progress.

## Interface
- DEPTH_BYTES, 1024: memory size in bytes; power of two, multiple of 4, minimum 16.
- AW, 32: width of `pc` and `load_base`.
- NOP, 32'h00000013: word returned when a fetch is invalid (`addi x0,x0,0`).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins a load at `load_base`.
- load_base  in  AW  byte start address, sampled with `load_start`; bits [1:0] are ignored (forced to 0).
- load_stop  in  1  ends the load, flushing any partial word.
- byte_valid  in  1  `byte_data` is valid.
- byte_data  in  8  program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- busy  out  1  high in LOAD and FLUSH.
- load_done  out  1  one-cycle pulse when a load finishes.
- overflow  out  1  sticky: load reached the end of memory; cleared by `load_start` or `rst`.
- word_count  out  AW  number of words written by the current or last load.
- fetch_en  in  1  fetch request.
- pc  in  AW  fetch byte address.
- instruction  out  32  fetched word, registered.
- instr_valid  out  1  `instruction` is a real memory word.
- fetch_fault  out  1  last fetch was misaligned, out of range, or made while busy.

## Operation
- Storage: `DEPTH_BYTES/4` words of 32 bits, word index = addr[log2(DEPTH_BYTES)-1:2]. Contents are not cleared by `rst`.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE -> LOAD on `load_start`. On entry: `wptr=load_base&~3`, `byte_cnt=0`, `word_count=0`, `overflow=0`.
  - LOAD: `byte_ready=1`. An accepted byte (`byte_valid&&byte_ready`) goes to lane `byte_cnt` of the pack register.
    - On the 4th byte, the word `{byte_data, pack[23:0]}` is written at `wptr` on the same edge, then `wptr+=4`, `word_count+=1`, `byte_cnt=0`.
  - LOAD -> FLUSH on `load_stop`. If a byte is accepted in the same cycle, that byte is included first.
  - LOAD -> DONE when a word write makes `wptr` equal `DEPTH_BYTES`. In that case `overflow=1` and `byte_ready` drops the next cycle. There is no wrap-around.
  - FLUSH (1 cycle): if `byte_cnt!=0`, write the pack register with unfilled lanes zeroed and increment `word_count`. If `byte_cnt==0`, nothing is written. Then go to DONE.
  - DONE (1 cycle): `load_done=1`, then go to IDLE.
- `load_start` is ignored outside IDLE.
- If `load_base>=DEPTH_BYTES`: go straight to DONE with `overflow=1` and write nothing.
- Fetch, evaluated on each edge where `fetch_en=1`:
  - Valid fetch (`pc[1:0]==0`, `pc<DEPTH_BYTES`, `busy==0`): `instruction=mem[pc]`, `instr_valid=1`, `fetch_fault=0`.
  - Otherwise: `instruction=NOP`, `instr_valid=0`, `fetch_fault=1`.
  - `fetch_en=0`: all three fetch outputs hold their values.
- Read and write to the same word on one edge: the fetch returns the old contents.

## Timing
- Reset values: state IDLE, `byte_ready=0`, `busy=0`, `load_done=0`, `overflow=0`, `word_count=0`, `instruction=NOP`, `instr_valid=0`, `fetch_fault=0`.
- Fetch latency: 1 cycle; outputs are registered.
- Load throughput: 1 byte per cycle. A word is readable by a fetch issued 2 cycles after its last byte is accepted, and only once the load has returned to IDLE.
- `load_done` is asserted 2 cycles after `load_stop` is sampled (FLUSH, then DONE).
- `busy` is high from the cycle after `load_start` through FLUSH. It is low in DONE.
- `rst` mid-load: the FSM returns to IDLE and the partial word is discarded. Words already written are retained.

## Test plan
- Load bytes 13,00,00,00,93,00,50,00 at base 0, then `load_stop` -> `word_count=2`. Fetch pc=0 gives 0x00000013; fetch pc=4 gives 0x00500093, each with `instr_valid=1`.
- Partial flush: load 3 bytes AA,BB,CC, then stop -> the word at base reads 0x00CCBBAA and `word_count=1`.
- Overflow: base `DEPTH_BYTES-8`, stream 12 bytes -> 2 words written, `overflow=1`, `byte_ready` low after the 8th byte, `load_done` pulses once.
- Fetch faults: pc=2 -> NOP with `fetch_fault=1`. pc=`DEPTH_BYTES` -> NOP with `fault=1`. Any fetch while `busy` -> NOP with `fault=1`.
- Reset mid-load after 6 bytes -> first word intact, outputs at their reset values, next `load_start` accepted.
- Back-pressure: `byte_valid` toggled every other cycle, `load_stop` asserted with the final byte -> all bytes are packed correctly with no loss.
